// File: rtl/edlo_pkg.sv
// Shared opcodes, field widths and FSM state type for the edlo fetch/decode/issue sequencer.
package edlo_pkg;

    localparam int OPC_W  = 4;
    localparam int OPND_W = 4;

    // Codes 3-8 are forwarded verbatim to the ALU stage and must track its decode.
    localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA_IMM = 4'h3;
    localparam logic [OPC_W-1:0] OP_LDB_IMM = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDA_RAM = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDB_RAM = 4'h6;
    localparam logic [OPC_W-1:0] OP_ADD     = 4'h7;
    localparam logic [OPC_W-1:0] OP_SUB     = 4'h8;
    localparam logic [OPC_W-1:0] OP_STR     = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP     = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ      = 4'hB;
    localparam logic [OPC_W-1:0] OP_HALT    = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_OPND2,
        S_RDWAIT,
        S_ISSUE,
        S_WB,
        S_HALT
    } state_e;

    // Opcodes whose second program byte is a branch target rather than ALU data.
    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc == OP_JMP) || (opc == OP_JZ);
    endfunction

endpackage

// File: rtl/edlo_sequencer_if.sv
// Program-memory, scratch-RAM and ALU-facing signals of the edlo sequencer.
interface edlo_sequencer_if
    import edlo_pkg::*;
#(
    parameter int PROG_AW = 8
);
    logic [PROG_AW-1:0] prog_addr;
    logic [7:0]         prog_data;
    logic [OPND_W-1:0]  ram_addr;
    logic               ram_we;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram_rdata;
    logic [OPC_W-1:0]   alu_inst;
    logic [7:0]         alu_data;
    logic [7:0]         alu_rtn;

    modport master (
        output prog_addr, ram_addr, ram_we, ram_wdata, alu_inst, alu_data,
        input  prog_data, ram_rdata, alu_rtn
    );

    modport slave (
        input  prog_addr, ram_addr, ram_we, ram_wdata, alu_inst, alu_data,
        output prog_data, ram_rdata, alu_rtn
    );
endinterface

// File: rtl/edlo_sequencer.sv
// Fetch/decode/issue controller for the 8-bit ALU stage; runs from PC=0 on start until HALT.
// Define EDLO_SEQ_BRANCH_ZERO_EN to decode opcode B as JZ (branch when alu_rtn == 0).
module edlo_sequencer
    import edlo_pkg::*;
#(
    parameter int PROG_AW = 8
)(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    edlo_sequencer_if.master  bus,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    state_e                 state_q, state_d;
    logic [PROG_AW-1:0]     pc_q, pc_d;
    logic [7:0]             ir_q, ir_d;
    logic [OPND_W-1:0]      ram_addr_q, ram_addr_d;
    logic [7:0]             alu_data_q, alu_data_d;
    logic                   err_q, err_d;

    logic [OPC_W-1:0]       dec_opc;
    logic [PROG_AW-1:0]     pc_inc;
    logic [PROG_AW-1:0]     tgt;

    assign dec_opc = bus.prog_data[7:4];
    assign pc_inc  = pc_q + PROG_AW'(1);
    assign tgt     = PROG_AW'(bus.prog_data);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ram_addr_q <= '0;
            alu_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ram_addr_q <= ram_addr_d;
            alu_data_q <= alu_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ram_addr_d = ram_addr_q;
        alu_data_d = alu_data_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = bus.prog_data;
                pc_d = pc_inc;
                case (dec_opc)
                    OP_NOP:                           state_d = S_FETCH;
                    OP_LDA_IMM, OP_LDB_IMM, OP_JMP:   state_d = S_OPND;
`ifdef EDLO_SEQ_BRANCH_ZERO_EN
                    OP_JZ:                            state_d = S_OPND;
`endif
                    OP_LDA_RAM, OP_LDB_RAM: begin
                        ram_addr_d = bus.prog_data[OPND_W-1:0];
                        state_d    = S_RDWAIT;
                    end
                    OP_ADD, OP_SUB:                   state_d = S_ISSUE;
                    OP_STR: begin
                        ram_addr_d = bus.prog_data[OPND_W-1:0];
                        state_d    = S_WB;
                    end
                    OP_HALT:                          state_d = S_HALT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_OPND: state_d = S_OPND2;
            S_OPND2: begin
                pc_d = pc_inc;
                if (is_branch(ir_q[7:4])) begin
                    // ir can only hold JZ here when the branch option decoded it.
                    if (ir_q[7:4] == OP_JMP || bus.alu_rtn == 8'h00)
                        pc_d = tgt;
                    state_d = S_FETCH;
                end else begin
                    alu_data_d = bus.prog_data;
                    state_d    = S_ISSUE;
                end
            end
            S_RDWAIT: state_d = S_ISSUE;
            S_ISSUE:  state_d = S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    assign bus.prog_addr = pc_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = (state_q == S_WB);
    assign bus.ram_wdata = (state_q == S_WB) ? bus.alu_rtn : 8'h00;
    assign bus.alu_inst  = (state_q == S_ISSUE) ? ir_q[7:4] : OP_NOP;
    assign bus.alu_data  = alu_data_q;

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted = (state_q == S_HALT);
    assign err    = err_q;

    // ram_rdata is routed to the ALU externally; operand nibble is consumed at decode.
    logic unused_sig;
    assign unused_sig = ^{ir_q[OPND_W-1:0], bus.ram_rdata};

endmodule

// File: tb/tb_edlo_sequencer.sv
// Self-checking bench: directed and random programs against an instruction-level reference model.
module tb_edlo_sequencer;
    import edlo_pkg::*;

    typedef struct packed {
        logic [3:0] kind;  // 1 = ALU issue, 2 = RAM write
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } ev_t;

    logic clock;
    logic rst_n;
    logic start;
    logic busy, halted, err;

    edlo_sequencer_if #(.PROG_AW(8)) bus ();

    edlo_sequencer #(.PROG_AW(8)) dut (
        .clock  (clock),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Environment: sync program ROM, scratch RAM and a small ALU.
    logic [7:0] pmem [256];
    logic [7:0] ram  [16];
    logic [7:0] prog_data_r = 8'h00;
    logic [7:0] ram_rdata_r = 8'h00;
    logic [7:0] alu_a = 8'h00, alu_b = 8'h00, alu_rtn_r = 8'h00;

    assign bus.prog_data = prog_data_r;
    assign bus.ram_rdata = ram_rdata_r;
    assign bus.alu_rtn   = alu_rtn_r;

    always @(posedge clock) begin
        prog_data_r <= pmem[bus.prog_addr];
        ram_rdata_r <= ram[bus.ram_addr];
        if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
    end

    always @(posedge clock) begin
        case (bus.alu_inst)
            4'h3: alu_a <= bus.alu_data;
            4'h4: alu_b <= bus.alu_data;
            4'h5: alu_a <= bus.ram_rdata;
            4'h6: alu_b <= bus.ram_rdata;
            4'h7: alu_rtn_r <= alu_a + alu_b;
            4'h8: alu_rtn_r <= alu_a - alu_b;
            default: ;
        endcase
    end

    // Monitor: log issued ALU ops and RAM writes, count busy cycles.
    ev_t        obs_q [$];
    int         busy_cyc = 0;
    logic [3:0] prev_ram_addr = 4'h0;

    always @(negedge clock) begin
        ev_t ev;
        if (busy) busy_cyc <= busy_cyc + 1;
        prev_ram_addr <= bus.ram_addr;
        if (bus.alu_inst != 4'h0) begin
            ev.kind = 4'h1;
            ev.a    = {4'h0, bus.alu_inst};
            ev.b    = 8'h00;
            ev.c    = 8'h00;
            if (bus.alu_inst == 4'h3 || bus.alu_inst == 4'h4) ev.b = bus.alu_data;
            if (bus.alu_inst == 4'h5 || bus.alu_inst == 4'h6) begin
                ev.b = bus.ram_rdata;
                ev.c = {4'h0, prev_ram_addr};
            end
            obs_q.push_back(ev);
        end
        if (bus.ram_we) begin
            ev.kind = 4'h2;
            ev.a    = {4'h0, bus.ram_addr};
            ev.b    = bus.ram_wdata;
            ev.c    = 8'h00;
            obs_q.push_back(ev);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c);
        ev_t e;
        e.kind = 4'(kind);
        e.a = a;
        e.b = b;
        e.c = c;
        return e;
    endfunction

    // Instruction-level reference: architectural PC, ALU A/B/RTN, RAM image, err, cycle cost.
    ev_t        exp_q [$];
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_rtn = 8'h00;

    task automatic model_run(output int cyc, output bit e, output int fpc);
        int         pc;
        logic [7:0] op, arg;
        logic [3:0] opc, opnd;
        logic [7:0] r [16];
        bit         done;
        for (int i = 0; i < 16; i++) r[i] = ram[i];
        exp_q.delete();
        pc = 0; cyc = 0; e = 1'b0; done = 1'b0; fpc = 0;
        for (int s = 0; s < 3000 && !done; s++) begin
            op = pmem[pc]; opc = op[7:4]; opnd = op[3:0];
            pc = (pc + 1) % 256;
            case (opc)
                4'h0: cyc += 2;
                4'h3, 4'h4: begin
                    arg = pmem[pc]; pc = (pc + 1) % 256; cyc += 5;
                    if (opc == 4'h3) m_a = arg; else m_b = arg;
                    exp_q.push_back(mk_ev(1, {4'h0, opc}, arg, 8'h00));
                end
                4'h5, 4'h6: begin
                    cyc += 4;
                    if (opc == 4'h5) m_a = r[opnd]; else m_b = r[opnd];
                    exp_q.push_back(mk_ev(1, {4'h0, opc}, r[opnd], {4'h0, opnd}));
                end
                4'h7, 4'h8: begin
                    cyc += 3;
                    m_rtn = (opc == 4'h7) ? m_a + m_b : m_a - m_b;
                    exp_q.push_back(mk_ev(1, {4'h0, opc}, 8'h00, 8'h00));
                end
                4'h9: begin
                    cyc += 3;
                    r[opnd] = m_rtn;
                    exp_q.push_back(mk_ev(2, {4'h0, opnd}, m_rtn, 8'h00));
                end
                4'hA: begin
                    cyc += 4;
                    pc = int'(pmem[pc]);
                end
`ifdef EDLO_SEQ_BRANCH_ZERO_EN
                4'hB: begin
                    cyc += 4;
                    if (m_rtn == 8'h00) pc = int'(pmem[pc]);
                    else pc = (pc + 1) % 256;
                end
`endif
                4'hF: begin
                    cyc += 2;
                    fpc = pc;
                    done = 1'b1;
                end
                default: begin
                    cyc += 2;
                    e = 1'b1;
                end
            endcase
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    endtask

    task automatic run_prog(input string tag, input int extra_start);
        int cyc, fpc, base, c0, k;
        bit e;
        model_run(cyc, e, fpc);
        base = obs_q.size();
        c0   = busy_cyc;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        k = 0;
        while (!halted && k < 5000) begin
            @(negedge clock);
            start = (k == extra_start);
            k++;
        end
        start = 1'b0;
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cycles"}, busy_cyc - c0, cyc);
        chk({tag, "_err"}, err, e);
        chk({tag, "_pc"}, {24'h0, bus.prog_addr}, fpc);
        chk({tag, "_alu_inst_idle"}, bus.alu_inst, 0);
        chk({tag, "_nevents"}, obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs_q.size()) chk({tag, "_event"}, obs_q[base + i], exp_q[i]);
    endtask

    logic [3:0] optab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hE};

    initial begin
        int   a, k;
        logic [3:0] opc;
        logic [7:0] saved;
        ev_t  last_wr;

        rst_n = 1'b0;
        start = 1'b0;
        clear_prog();
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        repeat (3) @(negedge clock);

        // Reset values
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_prog_addr", bus.prog_addr, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_alu_inst", bus.alu_inst, 0);
        chk("rst_alu_data", bus.alu_data, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // LDA #5, LDB #3, ADD, STR 0, HALT
        clear_prog();
        pmem[0] = 8'h30; pmem[1] = 8'h05; pmem[2] = 8'h40; pmem[3] = 8'h03;
        pmem[4] = 8'h70; pmem[5] = 8'h90; pmem[6] = 8'hF0;
        run_prog("imm_add_str", -1);
        last_wr = obs_q[obs_q.size() - 1];
        chk("imm_add_str_write", last_wr, mk_ev(2, 8'h00, 8'h08, 8'h00));
        chk("imm_add_str_ram0", ram[0], 8'h08);

        // LDA [2], LDB [3], SUB
        clear_prog();
        ram[2] = 8'h0A; ram[3] = 8'h04;
        pmem[0] = 8'h52; pmem[1] = 8'h63; pmem[2] = 8'h80; pmem[3] = 8'hF0;
        run_prog("ram_sub", -1);

        // JMP at FE with operand at FF
        clear_prog();
        pmem[0] = 8'hA0; pmem[1] = 8'hFE; pmem[8'hFE] = 8'hA0; pmem[8'hFF] = 8'h10;
        pmem[8'h10] = 8'hF0;
        run_prog("jmp_fe", -1);
        chk("jmp_fe_pc_const", bus.prog_addr, 8'h11);

        // JMP at FF: operand byte wraps to address 0
        clear_prog();
        pmem[0] = 8'hA0; pmem[1] = 8'hFF; pmem[8'hFF] = 8'hA0; pmem[8'hA0] = 8'hF0;
        run_prog("jmp_ff", -1);

        // NOP at FF falls through to 00; address 0 is patched to HALT once the PC gets there
        clear_prog();
        pmem[0] = 8'hA0; pmem[1] = 8'hFD;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        k = 0;
        while (bus.prog_addr != 8'hFF && k < 200) begin @(negedge clock); k++; end
        chk("wrap_reach_ff", bus.prog_addr, 8'hFF);
        pmem[0] = 8'hF0;
        k = 0;
        while (!halted && k < 200) begin @(negedge clock); k++; end
        chk("wrap_halted", halted, 1);
        chk("wrap_pc", bus.prog_addr, 8'h01);

        // Illegal opcodes: no ALU issue, sticky err
        clear_prog();
        pmem[0] = 8'h10; pmem[1] = 8'hC0; pmem[2] = 8'h00; pmem[3] = 8'h2F; pmem[4] = 8'hF0;
        run_prog("illegal", -1);
        chk("illegal_err_const", err, 1);
        @(negedge clock);
        chk("illegal_err_held", err, 1);
        clear_prog();
        pmem[0] = 8'h00; pmem[1] = 8'hF0;
        run_prog("err_clear", -1);
        chk("err_clear_const", err, 0);

        // start while busy is ignored
        clear_prog();
        for (int i = 0; i < 8; i++) pmem[i] = 8'h00;
        pmem[8] = 8'hF0;
        run_prog("start_busy", 4);

        // Branch-on-zero (or illegal B without the option)
        clear_prog();
        pmem[0] = 8'h30; pmem[1] = 8'h00; pmem[2] = 8'h40; pmem[3] = 8'h00; pmem[4] = 8'h70;
        pmem[5] = 8'hB0; pmem[6] = 8'h20; pmem[7] = 8'hF0; pmem[8'h20] = 8'hF0;
        run_prog("jz_zero", -1);
`ifdef EDLO_SEQ_BRANCH_ZERO_EN
        chk("jz_zero_pc_const", bus.prog_addr, 8'h21);
        chk("jz_zero_err_const", err, 0);
`else
        chk("b_illegal_err_const", err, 1);
`endif
        pmem[1] = 8'h01;
        run_prog("jz_nonzero", -1);
`ifdef EDLO_SEQ_BRANCH_ZERO_EN
        chk("jz_nonzero_pc_const", bus.prog_addr, 8'h08);
        chk("jz_nonzero_err_const", err, 0);
`endif

        // Random straight-line programs
        for (int t = 0; t < 25; t++) begin
            clear_prog();
            for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
            a = 0;
            repeat ($urandom_range(4, 16)) begin
                opc = optab[$urandom_range(0, 11)];
                pmem[a] = {opc, 4'($urandom_range(0, 15))};
                a++;
                if (opc == 4'h3 || opc == 4'h4) begin
                    pmem[a] = 8'($urandom);
                    a++;
                end
            end
            pmem[a] = 8'hF0;
            run_prog("random", -1);
        end

        // Reset during WB drops the write immediately
        clear_prog();
        pmem[0] = 8'h95; pmem[1] = 8'hF0;
        saved = ram[5];
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        k = 0;
        while (!bus.ram_we && k < 20) begin @(negedge clock); k++; end
        chk("wb_reached", bus.ram_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("wb_rst_ram_we", bus.ram_we, 0);
        chk("wb_rst_busy", busy, 0);
        chk("wb_rst_halted", halted, 0);
        chk("wb_rst_pc", bus.prog_addr, 0);
        chk("wb_rst_ram_addr", bus.ram_addr, 0);
        @(negedge clock);
        chk("wb_rst_ram_kept", ram[5], saved);
        rst_n = 1'b1;
        @(negedge clock);
        chk("wb_rst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/edlo_sequencer.md
Name: edlo_sequencer

Overview:
- Instruction fetch/decode/issue controller sitting directly upstream of the 8-bit ALU stage.
- Reads a byte-wide program memory, drives the ALU's 4-bit instruction code and 8-bit immediate data, and sequences the scratch RAM so that `ram_in` is valid when the ALU samples it.
- Writes the ALU result back to RAM on store instructions.
- Started by a one-cycle `start` pulse; runs until HALT.

Parameters:
- PROG_AW, 8, program memory address width; the PC wraps modulo 2^PROG_AW.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins execution at PC=0 when idle or halted.
- prog_addr  out  PROG_AW  program memory address; equals the PC register.
- prog_data  in  8  program byte; sync memory, valid one cycle after prog_addr.
- ram_addr  out  4  scratch RAM address; registered.
- ram_we  out  1  RAM write strobe, one cycle.
- ram_wdata  out  8  RAM write data; equals alu_rtn while ram_we=1, else 0.
- ram_rdata  in  8  RAM read data, valid one cycle after ram_addr; routed externally to the ALU ram_in.
- alu_inst  out  4  ALU instruction code; 0 when no operation is issued.
- alu_data  out  8  immediate byte to the ALU data_in.
- alu_rtn  in  8  ALU RTN result.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky; set on an illegal opcode, cleared by reset or start.

Behaviour:
- Instruction byte format: [7:4] opcode, [3:0] operand (RAM address).
- Opcodes:
  - 0 NOP.
  - 3 LDA imm, 4 LDB imm: two bytes, second byte is the immediate.
  - 5 LDA ram, 6 LDB ram.
  - 7 ADD, 8 SUB.
  - 9 STR: RAM[operand] <= alu_rtn.
  - A JMP: two bytes, second byte is the target (low PROG_AW bits).
  - F HALT.
  - 1, 2, B-E are illegal: executed as NOP and set err.
- Reset values: PC=0, state IDLE, ram_addr=0, ram_we=0, alu_inst=0, alu_data=0, busy=0, halted=0, err=0, IR=0.
- States and transitions:
  - IDLE: waits for start, then PC<=0, err<=0, go to FETCH.
  - FETCH: prog_addr=PC; go to DECODE.
  - DECODE: IR<=prog_data, PC<=PC+1. Dispatch:
    - NOP/illegal -> FETCH.
    - 3/4/A -> OPND.
    - 5/6 -> RDWAIT, with ram_addr<=operand.
    - 7/8 -> ISSUE.
    - 9 -> WB, with ram_addr<=operand.
    - F -> HALT.
  - OPND: prog_addr=PC (operand byte address); go to OPND2.
  - OPND2: PC<=PC+1.
    - For opcode A: PC<=prog_data instead; go to FETCH.
    - Else alu_data<=prog_data; go to ISSUE.
  - RDWAIT: RAM read in flight; go to ISSUE. ram_rdata is valid during ISSUE.
  - ISSUE: alu_inst=IR[7:4] for exactly this one cycle; go to FETCH.
  - WB: ram_we=1, ram_wdata=alu_rtn; go to FETCH.
  - HALT: holds. start -> FETCH with PC=0, err<=0.
- Latency in cycles: NOP 2, ADD/SUB 3, LDA/LDB ram 4, STR 3, LDA/LDB imm 5, JMP 4.
- alu_inst is 0 in every state other than ISSUE. The ALU ignores code 0.
- ALU result timing: RTN updates on the edge that ends ISSUE. A STR that immediately follows ADD/SUB sees the new result, because FETCH and DECODE intervene.
- PC increments wrap from 2^PROG_AW-1 to 0 silently. An operand byte at the wrap address is read from address 0.
- start while busy is ignored.
- Reset asserted mid-instruction: all outputs return to reset values immediately. An in-flight ram_we is dropped. ALU internal registers are not reset by this block.
- An illegal opcode sets err in DECODE; err stays set until reset or start.

Optional Feature:
- Macro: EDLO_SEQ_BRANCH_ZERO_EN.
- Defined: opcode B is JZ, two bytes. In OPND2, PC<=target if alu_rtn==8'h00, else PC<=PC+1. Latency 4 cycles either way. err is not set.
- Undefined: B is illegal (NOP + err).

Decomposition:
- Shared package edlo_pkg:
  - Opcode constants OP_NOP..OP_HALT; the ALU-facing codes 3-8 must match the ALU stage's codes.
  - State enum type.
  - Instruction field widths (OPC_W=4, OPND_W=4).
- No sub-module; a single FSM plus PC/IR/datapath registers.

Test Plan:
- Reset, then start with program {30 05, 40 03, 70, 90, F0}: alu_inst sequence 3 (alu_data=05), 4 (alu_data=03), 7. With alu_rtn modelled as 08, ram_we writes 08 at address 0. halted=1 and busy=0 at the end.
- Program {52, 63, 80, F0} with RAM[2]=0A, RAM[3]=04: ram_addr=2 one cycle before alu_inst=5 and ram_rdata=0A during that cycle; same pattern for 6; then alu_inst=8.
- JMP wrap: PROG_AW=8, JMP at FE: A0 at FE, operand at FF, FF=10 -> next fetch at 10. Place NOP at FF with no JMP -> next fetch at 00.
- Opcode 0x1 or 0xC: no alu_inst, err=1 persists; start after HALT clears err.
- Reset asserted during WB: ram_we falls asynchronously, state IDLE, busy=0, PC=0. start during busy: no effect.
- With EDLO_SEQ_BRANCH_ZERO_EN: B0 20 with alu_rtn=00 -> fetch 20; with alu_rtn=01 -> fall through, err=0. Without the macro: err=1.
